width_conv_fifo: RTL and testbench

Single-clock, parametrised width-converting FIFO for the DDR3 controller data path. It packs narrow user words into wide DDR words (MODE=0) or unpacks wide DDR words into narrow user words (MODE=1). It stores wide words in one RAM, reports water levels in the units of each side, and adds almost-full/almost-empty thresholds, sticky overflow/underflow flags and a synchronous flush. It sits between the video/user side and the DDR3 read/write arbiter in the 100 MHz domain.

---
 rtl/width_conv_fifo.sv | 238 +++++++++++++++++++++++
 tb/tb_width_conv_fifo.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/width_conv_fifo.sv
// width_conv_fifo
//
// Single-clock width-converting FIFO between the user/video side and the DDR3
// arbiter. MODE=0 packs RATIO narrow writes into one wide word; MODE=1 unpacks
// each wide word into RATIO narrow reads. Storage is always in wide words.
// Lane order is little-endian: narrow word k sits at [k*NARROW_W +: NARROW_W].
//
// Ports:
//   clk_100      in   clock, all logic rising-edge
//   rst_n        in   asynchronous active-low reset
//   flush        in   synchronous clear of contents and flags (beats wr_en/rd_en)
//   wr_en        in   write request
//   wr_data      in   write data (IN_W)
//   wr_full      out  write rejected this cycle
//   almost_full  out  wr_level >= AFULL_TH
//   wr_level     out  occupancy in write-side units
//   rd_en        in   read request
//   rd_data      out  registered read data (OUT_W), valid the cycle after rd_en
//   rd_empty     out  read rejected this cycle
//   almost_empty out  rd_level <= AEMPTY_TH
//   rd_level     out  occupancy in read-side units
//   overflow     out  sticky, set by a write while wr_full
//   underflow    out  sticky, set by a read while rd_empty

module width_conv_fifo #(
    parameter int unsigned NARROW_W   = 16,
    parameter int unsigned RATIO_LOG2 = 3,
    parameter int unsigned DEPTH_W    = 10,
    parameter int unsigned MODE       = 0,
    parameter int unsigned AFULL_TH   = 1000,
    parameter int unsigned AEMPTY_TH  = 2,
    localparam int unsigned RATIO     = 1 << RATIO_LOG2,
    localparam int unsigned WIDE_W    = NARROW_W * RATIO,
    localparam int unsigned IN_W      = (MODE != 0) ? WIDE_W : NARROW_W,
    localparam int unsigned OUT_W     = (MODE != 0) ? NARROW_W : WIDE_W,
    localparam int unsigned LVL_W     = DEPTH_W + RATIO_LOG2 + 1
) (
    input  logic             clk_100,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [IN_W-1:0]  wr_data,
    output logic             wr_full,
    output logic             almost_full,
    output logic [LVL_W-1:0] wr_level,
    input  logic             rd_en,
    output logic [OUT_W-1:0] rd_data,
    output logic             rd_empty,
    output logic             almost_empty,
    output logic [LVL_W-1:0] rd_level,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_W;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDE_W-1:0]     mem [DEPTH];

    logic [DEPTH_W-1:0]    wptr_q, wptr_d;
    logic [DEPTH_W-1:0]    rptr_q, rptr_d;
    logic [DEPTH_W:0]      mcnt_q, mcnt_d;
    // Lane counter: pcnt (accumulator fill) in pack mode, lidx (head lane) in
    // unpack mode. Only one of the two is ever needed, so they share a register.
    logic [RATIO_LOG2-1:0] lane_q, lane_d;
    logic [OUT_W-1:0]      rd_data_q, rd_data_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic              wr_accept, rd_accept;
    logic              last_lane;
    logic              push, pop, lane_step;
    logic [WIDE_W-1:0] push_word;
    logic [OUT_W-1:0]  pop_data;

    // mcnt never exceeds DEPTH, so its top bit alone marks full.
    assign wr_full  = mcnt_q[DEPTH_W];
    assign rd_empty = (mcnt_q == '0);

    // flush wins over both requests, so nothing is accepted in a flush cycle.
    assign wr_accept = wr_en & ~wr_full & ~flush;
    assign rd_accept = rd_en & ~rd_empty & ~flush;

    // RATIO is a power of two, so the last lane is the all-ones count.
    assign last_lane = &lane_q;

    always_comb begin
        if (MODE == 0) begin
            push      = wr_accept & last_lane;
            pop       = rd_accept;
            lane_step = wr_accept;
        end else begin
            push      = wr_accept;
            pop       = rd_accept & last_lane;
            lane_step = rd_accept;
        end
    end

    // ------------------------------------------------------------------
    // Mode-specific data paths
    // ------------------------------------------------------------------
    if (MODE == 0) begin : g_pack
        logic [WIDE_W-1:0] acc_q, acc_d;

        // The incoming narrow word is merged into its lane; on the last lane the
        // merged word goes straight to RAM without waiting for another cycle.
        always_comb begin
            acc_d = acc_q;
            acc_d[lane_q*NARROW_W +: NARROW_W] = wr_data;
        end

        // Every lane is rewritten before a push, so stale contents never leak
        // out and the accumulator needs no reset or flush.
        always_ff @(posedge clk_100) begin
            if (wr_accept) begin
                acc_q <= acc_d;
            end
        end

        assign push_word = acc_d;
        assign pop_data  = mem[rptr_q];
    end else begin : g_unpack
        logic [WIDE_W-1:0] head_word;

        assign head_word = mem[rptr_q];
        assign push_word = wr_data;
        assign pop_data  = head_word[lane_q*NARROW_W +: NARROW_W];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        mcnt_d      = mcnt_q;
        lane_d      = lane_q;
        rd_data_d   = rd_data_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            mcnt_d      = '0;
            lane_d      = '0;
            rd_data_d   = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            if (push && !pop) begin
                mcnt_d = mcnt_q + 1'b1;
            end else if (pop && !push) begin
                mcnt_d = mcnt_q - 1'b1;
            end
            // Wraps back to lane 0 after RATIO-1 on its own.
            if (lane_step) begin
                lane_d = lane_q + 1'b1;
            end
            if (rd_accept) begin
                rd_data_d = pop_data;
            end
            if (wr_en && wr_full) begin
                overflow_d = 1'b1;
            end
            if (rd_en && rd_empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            mcnt_q      <= '0;
            lane_q      <= '0;
            rd_data_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            mcnt_q      <= mcnt_d;
            lane_q      <= lane_d;
            rd_data_q   <= rd_data_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array, no reset: contents are only observable through the pointers.
    always_ff @(posedge clk_100) begin
        if (push) begin
            mem[wptr_q] <= push_word;
        end
    end

    // ------------------------------------------------------------------
    // Levels and flags
    // ------------------------------------------------------------------
    logic [LVL_W-1:0] mcnt_lvl, lane_lvl, scaled_lvl;

    assign mcnt_lvl   = LVL_W'(mcnt_q);
    assign lane_lvl   = LVL_W'(lane_q);
    assign scaled_lvl = mcnt_lvl << RATIO_LOG2;

    always_comb begin
        if (MODE == 0) begin
            // Narrow words already in the accumulator count toward the write side.
            wr_level = scaled_lvl + lane_lvl;
            rd_level = mcnt_lvl;
        end else begin
            // Lanes already read from the head word no longer count.
            wr_level = mcnt_lvl;
            rd_level = scaled_lvl - lane_lvl;
        end
    end

    assign almost_full  = (32'(wr_level) >= AFULL_TH);
    assign almost_empty = (32'(rd_level) <= AEMPTY_TH);

    assign rd_data   = rd_data_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_width_conv_fifo.sv
// Bench for width_conv_fifo: a default pack instance, a 16-deep pack instance
// and a 16-deep unpack instance share one clock and reset.

module tb_width_conv_fifo;

    localparam int NW        = 16;
    localparam int R         = 8;
    localparam int P_DEPTH   = 1024;
    localparam int U_DEPTH   = 16;

    logic clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;
    logic rst_n;

    // Default pack instance
    logic         p_flush, p_wr_en, p_rd_en;
    logic [15:0]  p_wr_data;
    logic [127:0] p_rd_data;
    logic         p_wr_full, p_af, p_rd_empty, p_ae, p_ovf, p_udf;
    logic [13:0]  p_wr_level, p_rd_level;

    // Pack instance, DEPTH_W=4
    logic         s_flush, s_wr_en, s_rd_en;
    logic [15:0]  s_wr_data;
    logic [127:0] s_rd_data;
    logic         s_wr_full, s_af, s_rd_empty, s_ae, s_ovf, s_udf;
    logic [7:0]   s_wr_level, s_rd_level;

    // Unpack instance, DEPTH_W=4
    logic         u_flush, u_wr_en, u_rd_en;
    logic [127:0] u_wr_data;
    logic [15:0]  u_rd_data;
    logic         u_wr_full, u_af, u_rd_empty, u_ae, u_ovf, u_udf;
    logic [7:0]   u_wr_level, u_rd_level;

    width_conv_fifo u_pack (
        .clk_100(clk_100), .rst_n(rst_n), .flush(p_flush),
        .wr_en(p_wr_en), .wr_data(p_wr_data), .wr_full(p_wr_full),
        .almost_full(p_af), .wr_level(p_wr_level),
        .rd_en(p_rd_en), .rd_data(p_rd_data), .rd_empty(p_rd_empty),
        .almost_empty(p_ae), .rd_level(p_rd_level),
        .overflow(p_ovf), .underflow(p_udf)
    );

    width_conv_fifo #(.DEPTH_W(4)) u_pack_small (
        .clk_100(clk_100), .rst_n(rst_n), .flush(s_flush),
        .wr_en(s_wr_en), .wr_data(s_wr_data), .wr_full(s_wr_full),
        .almost_full(s_af), .wr_level(s_wr_level),
        .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_empty(s_rd_empty),
        .almost_empty(s_ae), .rd_level(s_rd_level),
        .overflow(s_ovf), .underflow(s_udf)
    );

    width_conv_fifo #(.DEPTH_W(4), .MODE(1)) u_unpack (
        .clk_100(clk_100), .rst_n(rst_n), .flush(u_flush),
        .wr_en(u_wr_en), .wr_data(u_wr_data), .wr_full(u_wr_full),
        .almost_full(u_af), .wr_level(u_wr_level),
        .rd_en(u_rd_en), .rd_data(u_rd_data), .rd_empty(u_rd_empty),
        .almost_empty(u_ae), .rd_level(u_rd_level),
        .overflow(u_ovf), .underflow(u_udf)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string t,
                           input logic [127:0] rd, input logic [13:0] wl, input logic [13:0] rl,
                           input logic wf, input logic re, input logic ae, input logic af,
                           input logic ov, input logic un,
                           input logic [127:0] e_rd, input logic [13:0] e_wl,
                           input logic [13:0] e_rl, input logic e_wf, input logic e_re,
                           input logic e_ae, input logic e_af, input logic e_ov,
                           input logic e_un);
        check({t, ".rd_data"},      rd,         e_rd);
        check({t, ".wr_level"},     128'(wl),   128'(e_wl));
        check({t, ".rd_level"},     128'(rl),   128'(e_rl));
        check({t, ".wr_full"},      128'(wf),   128'(e_wf));
        check({t, ".rd_empty"},     128'(re),   128'(e_re));
        check({t, ".almost_empty"}, 128'(ae),   128'(e_ae));
        check({t, ".almost_full"},  128'(af),   128'(e_af));
        check({t, ".overflow"},     128'(ov),   128'(e_ov));
        check({t, ".underflow"},    128'(un),   128'(e_un));
    endtask

    task automatic chk_reset_p(input string t);
        chk_out({t, ".p"}, p_rd_data, p_wr_level, p_rd_level, p_wr_full, p_rd_empty, p_ae,
                p_af, p_ovf, p_udf, '0, 14'd0, 14'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_s(input string t);
        chk_out({t, ".s"}, s_rd_data, 14'(s_wr_level), 14'(s_rd_level), s_wr_full,
                s_rd_empty, s_ae, s_af, s_ovf, s_udf,
                '0, 14'd0, 14'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_u(input string t);
        chk_out({t, ".u"}, 128'(u_rd_data), 14'(u_wr_level), 14'(u_rd_level), u_wr_full,
                u_rd_empty, u_ae, u_af, u_ovf, u_udf,
                '0, 14'd0, 14'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    // Reference models: a plain queue of narrow words in arrival order.
    logic [15:0]  pq[$];
    logic [127:0] exp_p_rd;
    logic         exp_p_ovf, exp_p_udf;
    logic [15:0]  uq[$];
    logic [15:0]  exp_u_rd;
    logic         exp_u_ovf, exp_u_udf;

    task automatic p_rand_step(input int unsigned wr_pct, input int unsigned rd_pct);
        logic         we, re, wacc, racc;
        logic [15:0]  d;
        logic [127:0] w;
        int           lvl;
        we   = ($urandom_range(0, 99) < wr_pct);
        re   = ($urandom_range(0, 99) < rd_pct);
        d    = 16'($urandom());
        wacc = we && (pq.size() / R < P_DEPTH);
        racc = re && (pq.size() / R > 0);
        if (we && !wacc) exp_p_ovf = 1'b1;
        if (re && !racc) exp_p_udf = 1'b1;
        if (racc) begin
            for (int i = 0; i < R; i++) w[i*NW +: NW] = pq.pop_front();
            exp_p_rd = w;
        end
        if (wacc) pq.push_back(d);
        p_wr_en = we; p_rd_en = re; p_wr_data = d;
        tick();
        p_wr_en = 1'b0; p_rd_en = 1'b0;
        lvl = pq.size();
        chk_out("p_rand", p_rd_data, p_wr_level, p_rd_level, p_wr_full, p_rd_empty, p_ae,
                p_af, p_ovf, p_udf, exp_p_rd, 14'(lvl), 14'(lvl / R),
                (lvl / R) == P_DEPTH, (lvl / R) == 0, (lvl / R) <= 2, lvl >= 1000,
                exp_p_ovf, exp_p_udf);
    endtask

    task automatic u_rand_step(input int unsigned wr_pct, input int unsigned rd_pct);
        logic         we, re, wacc, racc;
        logic [127:0] w;
        int           lvl, words;
        we   = ($urandom_range(0, 99) < wr_pct);
        re   = ($urandom_range(0, 99) < rd_pct);
        w    = {$urandom(), $urandom(), $urandom(), $urandom()};
        wacc = we && ((uq.size() + R - 1) / R < U_DEPTH);
        racc = re && (uq.size() > 0);
        if (we && !wacc) exp_u_ovf = 1'b1;
        if (re && !racc) exp_u_udf = 1'b1;
        if (racc) exp_u_rd = uq.pop_front();
        if (wacc) for (int i = 0; i < R; i++) uq.push_back(w[i*NW +: NW]);
        u_wr_en = we; u_rd_en = re; u_wr_data = w;
        tick();
        u_wr_en = 1'b0; u_rd_en = 1'b0;
        lvl   = uq.size();
        words = (lvl + R - 1) / R;
        chk_out("u_rand", 128'(u_rd_data), 14'(u_wr_level), 14'(u_rd_level), u_wr_full,
                u_rd_empty, u_ae, u_af, u_ovf, u_udf, 128'(exp_u_rd), 14'(words), 14'(lvl),
                words == U_DEPTH, lvl == 0, lvl <= 2, words >= 1000, exp_u_ovf, exp_u_udf);
    endtask

    initial begin
        logic [127:0] w;
        logic [15:0]  sq[$];
        int           n;

        rst_n = 1'b0;
        p_flush = 0; p_wr_en = 0; p_rd_en = 0; p_wr_data = '0;
        s_flush = 0; s_wr_en = 0; s_rd_en = 0; s_wr_data = '0;
        u_flush = 0; u_wr_en = 0; u_rd_en = 0; u_wr_data = '0;
        #12;
        chk_reset_p("por"); chk_reset_s("por"); chk_reset_u("por");
        @(negedge clk_100);
        rst_n = 1'b1;

        // Pack, defaults: 16 narrow words make two wide words
        for (int i = 1; i <= 16; i++) begin
            p_wr_en = 1'b1; p_wr_data = 16'(i); tick();
        end
        p_wr_en = 1'b0;
        check("pack16.wr_level", 128'(p_wr_level), 128'(16));
        check("pack16.rd_level", 128'(p_rd_level), 128'(2));
        check("pack16.rd_empty", 128'(p_rd_empty), 128'(0));
        check("pack16.almost_empty", 128'(p_ae), 128'(1));
        p_rd_en = 1'b1; tick(); p_rd_en = 1'b0;
        check("pack16.rd_data", p_rd_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        check("pack16.rd_level_after", 128'(p_rd_level), 128'(1));
        check("pack16.wr_level_after", 128'(p_wr_level), 128'(8));
        p_flush = 1'b1; tick(); p_flush = 1'b0;
        chk_reset_p("flush1");

        // Partial accumulator is not readable, then flush
        for (int i = 0; i < 3; i++) begin
            p_wr_en = 1'b1; p_wr_data = 16'(16'hA0 + i); tick();
        end
        p_wr_en = 1'b0;
        check("partial.wr_level", 128'(p_wr_level), 128'(3));
        check("partial.rd_level", 128'(p_rd_level), 128'(0));
        check("partial.rd_empty", 128'(p_rd_empty), 128'(1));
        p_flush = 1'b1; tick(); p_flush = 1'b0;
        chk_reset_p("flush2");

        // almost_full boundary at 1000 narrow words
        for (int i = 0; i < 999; i++) begin
            p_wr_en = 1'b1; p_wr_data = 16'(i); tick();
        end
        p_wr_en = 1'b0;
        check("afull999.almost_full", 128'(p_af), 128'(0));
        p_wr_en = 1'b1; tick(); p_wr_en = 1'b0;
        check("afull1000.almost_full", 128'(p_af), 128'(1));
        check("afull1000.wr_level", 128'(p_wr_level), 128'(1000));
        check("afull1000.rd_level", 128'(p_rd_level), 128'(125));
        p_flush = 1'b1; tick(); p_flush = 1'b0;

        // Randomized pack traffic against the narrow-word queue model
        pq.delete(); exp_p_rd = '0; exp_p_ovf = 1'b0; exp_p_udf = 1'b0;
        for (int i = 0; i < 800; i++) p_rand_step(75, 10);

        // Full / overflow on the 16-deep pack instance
        for (int i = 0; i < 128; i++) begin
            s_wr_en = 1'b1; s_wr_data = 16'(i); tick();
        end
        s_wr_en = 1'b0;
        check("full.wr_full", 128'(s_wr_full), 128'(1));
        check("full.wr_level", 128'(s_wr_level), 128'(128));
        check("full.rd_level", 128'(s_rd_level), 128'(16));
        s_wr_en = 1'b1; s_wr_data = 16'hBEEF; tick(); s_wr_en = 1'b0;
        check("ovf.wr_level", 128'(s_wr_level), 128'(128));
        check("ovf.overflow", 128'(s_ovf), 128'(1));
        // Pop while full with a write in the same cycle: the write is still dropped
        s_wr_en = 1'b1; s_wr_data = 16'hCAFE; s_rd_en = 1'b1; tick();
        s_wr_en = 1'b0; s_rd_en = 1'b0;
        for (int i = 0; i < R; i++) w[i*NW +: NW] = 16'(i);
        check("popfull.wr_full", 128'(s_wr_full), 128'(0));
        check("popfull.wr_level", 128'(s_wr_level), 128'(120));
        check("popfull.overflow", 128'(s_ovf), 128'(1));
        check("popfull.rd_data", s_rd_data, w);
        s_flush = 1'b1; tick(); s_flush = 1'b0;

        // Wrap and concurrency: hold rd_level=5 while 40 wide words pass through
        sq.delete(); n = 0;
        for (int i = 0; i < 40; i++) begin
            s_wr_en = 1'b1; s_wr_data = 16'(n); sq.push_back(16'(n)); n++; tick();
        end
        s_wr_en = 1'b0;
        check("wrap.rd_level0", 128'(s_rd_level), 128'(5));
        for (int p = 0; p < 40; p++) begin
            for (int c = 0; c < R; c++) begin
                s_wr_en = 1'b1; s_wr_data = 16'(n); n++;
                s_rd_en = (c == p % R);
                if (s_rd_en) for (int i = 0; i < R; i++) w[i*NW +: NW] = sq.pop_front();
                sq.push_back(s_wr_data);
                tick();
            end
            s_wr_en = 1'b0; s_rd_en = 1'b0;
            check("wrap.rd_level", 128'(s_rd_level), 128'(5));
            check("wrap.wr_level", 128'(s_wr_level), 128'(40));
            check("wrap.rd_data", s_rd_data, w);
        end
        s_flush = 1'b1; tick(); s_flush = 1'b0;

        // Unpack: one wide word out as eight narrow words, then underflow
        u_wr_data = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
        u_wr_en = 1'b1; tick(); u_wr_en = 1'b0;
        check("unpack.rd_level", 128'(u_rd_level), 128'(8));
        check("unpack.wr_level", 128'(u_wr_level), 128'(1));
        check("unpack.almost_empty", 128'(u_ae), 128'(0));
        for (int i = 1; i <= 8; i++) begin
            u_rd_en = 1'b1; tick();
            check("unpack.rd_data", 128'(u_rd_data), 128'(i));
        end
        u_rd_en = 1'b0;
        check("unpack.rd_empty", 128'(u_rd_empty), 128'(1));
        check("unpack.rd_level_end", 128'(u_rd_level), 128'(0));
        check("unpack.underflow_pre", 128'(u_udf), 128'(0));
        u_rd_en = 1'b1; tick(); u_rd_en = 1'b0;
        check("unpack.underflow", 128'(u_udf), 128'(1));
        check("unpack.rd_data_hold", 128'(u_rd_data), 128'(8));
        u_flush = 1'b1; tick(); u_flush = 1'b0;
        chk_reset_u("uflush");

        // Randomized unpack traffic: fill past full, then drain past empty
        uq.delete(); exp_u_rd = '0; exp_u_ovf = 1'b0; exp_u_udf = 1'b0;
        for (int i = 0; i < 600; i++) u_rand_step(20, 80);
        for (int i = 0; i < 300; i++) u_rand_step(3, 90);

        // Reset mid-operation with pcnt=5, mcnt=3 and sticky underflow set
        s_rd_en = 1'b1; tick(); s_rd_en = 1'b0;
        check("pre_rst.underflow", 128'(s_udf), 128'(1));
        for (int i = 0; i < 32; i++) begin
            s_wr_en = 1'b1; s_wr_data = 16'(16'h100 + i); tick();
        end
        s_wr_en = 1'b0;
        s_rd_en = 1'b1; tick(); s_rd_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_wr_en = 1'b1; s_wr_data = 16'(16'h200 + i); tick();
        end
        s_wr_en = 1'b0;
        check("pre_rst.wr_level", 128'(s_wr_level), 128'(29));
        check("pre_rst.rd_level", 128'(s_rd_level), 128'(3));
        @(negedge clk_100);
        rst_n = 1'b0;
        #1;
        chk_reset_s("async_rst"); chk_reset_p("async_rst"); chk_reset_u("async_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
